// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and controller for a single-port RAM.
// Define RAM_CLEAR_EN to zero the RAM after every reset before requests are served.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 2,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  cnt_a,
  output logic [CNT_WIDTH-1:0]  cnt_b
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // last_gnt_q = 1 means B won last, so A wins the next contention
  logic                  last_gnt_q, last_gnt_d;
  logic                  rvalid_a_q, rvalid_a_d;
  logic                  rvalid_b_q, rvalid_b_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic [CNT_WIDTH-1:0]  cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0]  cnt_b_q, cnt_b_d;

`ifdef RAM_CLEAR_EN
  typedef enum logic {CLEAR, SERVE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy       = 1'b0;
    case (state_q)
      CLEAR: begin
        busy       = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == '1) state_d = SERVE;
      end
      default: busy = 1'b0;
    endcase
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!busy) begin
      if (req_a && req_b) begin
        gnt_a = last_gnt_q;
        gnt_b = !last_gnt_q;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_a;
    mem_wdata = wdata_a;
    if (gnt_a) begin
      mem_we = we_a;
    end else if (gnt_b) begin
      mem_we    = we_b;
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
    end
`ifdef RAM_CLEAR_EN
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr_q;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk_2) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_a)      last_gnt_d = 1'b0;
    else if (gnt_b) last_gnt_d = 1'b1;

    rvalid_a_d = gnt_a && !we_a;
    rvalid_b_d = gnt_b && !we_b;
    rdata_a_d  = rvalid_a_d ? mem[addr_a] : rdata_a_q;
    rdata_b_d  = rvalid_b_d ? mem[addr_b] : rdata_b_q;

    cnt_a_d = (gnt_a && cnt_a_q != '1) ? cnt_a_q + CNT_WIDTH'(1) : cnt_a_q;
    cnt_b_d = (gnt_b && cnt_b_q != '1) ? cnt_b_q + CNT_WIDTH'(1) : cnt_b_q;
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
    end
  end

  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign cnt_a    = cnt_a_q;
  assign cnt_b    = cnt_b_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level model of the arbitration rules.
module tb_ram_arbiter;

  localparam int AW      = 2;
  localparam int DW      = 2;
  localparam int CW      = 4;
  localparam int DEPTH   = 1 << AW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_2 = 1'b0;
  logic          reset;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_mem [DEPTH];
  bit m_known [DEPTH];
  int m_last;
  int m_cnt_a, m_cnt_b, m_rdata_a, m_rdata_b;
  bit m_rvalid_a, m_rvalid_b, m_rdk_a, m_rdk_b;
  int m_clear_left;
  bit exp_gnt_a, exp_gnt_b, exp_busy;
  logic obs_gnt_a, obs_gnt_b, obs_busy;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_2(clk_2), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .busy(busy), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk_2 = ~clk_2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_last     = 1;
    m_cnt_a    = 0;
    m_cnt_b    = 0;
    m_rvalid_a = 0;
    m_rvalid_b = 0;
    m_rdata_a  = 0;
    m_rdata_b  = 0;
    m_rdk_a    = 1;
    m_rdk_b    = 1;
`ifdef RAM_CLEAR_EN
    m_clear_left = DEPTH;
`else
    m_clear_left = 0;
`endif
  endtask

  // Called just after a negedge with inputs driven; returns just after the next negedge.
  task automatic tick();
    #1;
    exp_busy  = (m_clear_left > 0);
    exp_gnt_a = 0;
    exp_gnt_b = 0;
    if (!exp_busy) begin
      if (req_a && req_b) begin
        if (m_last == 1) exp_gnt_a = 1;
        else             exp_gnt_b = 1;
      end else if (req_a) exp_gnt_a = 1;
      else if (req_b)     exp_gnt_b = 1;
    end
    obs_gnt_a = gnt_a;
    obs_gnt_b = gnt_b;
    obs_busy  = busy;
    @(posedge clk_2);
    m_rvalid_a = 0;
    m_rvalid_b = 0;
    if (m_clear_left > 0) begin
      m_mem[DEPTH - m_clear_left]   = 0;
      m_known[DEPTH - m_clear_left] = 1;
      m_clear_left--;
    end
    if (exp_gnt_a) begin
      m_last = 0;
      if (m_cnt_a < CNT_MAX) m_cnt_a++;
      if (we_a) begin
        m_mem[addr_a]   = int'(wdata_a);
        m_known[addr_a] = 1;
      end else begin
        m_rvalid_a = 1;
        m_rdata_a  = m_mem[addr_a];
        m_rdk_a    = m_known[addr_a];
      end
    end
    if (exp_gnt_b) begin
      m_last = 1;
      if (m_cnt_b < CNT_MAX) m_cnt_b++;
      if (we_b) begin
        m_mem[addr_b]   = int'(wdata_b);
        m_known[addr_b] = 1;
      end else begin
        m_rvalid_b = 1;
        m_rdata_b  = m_mem[addr_b];
        m_rdk_b    = m_known[addr_b];
      end
    end
    @(negedge clk_2);
  endtask

  task automatic apply_reset(input bit wait_clear);
    req_a = 0;
    req_b = 0;
    reset = 1;
    @(negedge clk_2);
    reset = 0;
    model_reset();
    if (wait_clear) while (m_clear_left > 0) tick();
  endtask

  task automatic test_reset();
    logic exp_b;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    reset = 1;
    @(negedge clk_2);
`ifdef RAM_CLEAR_EN
    exp_b = 1'b1;
`else
    exp_b = 1'b0;
`endif
    n_checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rvalid: got a=%0b b=%0b expected 0 0", rvalid_a, rvalid_b);
    end
    n_checks++;
    if (rdata_a !== '0 || rdata_b !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got a=%0d b=%0d expected 0 0", rdata_a, rdata_b);
    end
    n_checks++;
    if (cnt_a !== '0 || cnt_b !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got a=%0d b=%0d expected 0 0", cnt_a, cnt_b);
    end
    n_checks++;
    if (busy !== exp_b || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_gnt: got busy=%0b gnt=%0b%0b expected busy=%0b gnt=00",
               busy, gnt_a, gnt_b, exp_b);
    end
    reset = 0;
    model_reset();
    while (m_clear_left > 0) tick();
  endtask

  task automatic test_write_read();
    apply_reset(1);
    req_a = 1; we_a = 1; addr_a = 2'd2; wdata_a = 2'd3;
    tick();
    n_checks++;
    if (obs_gnt_a !== 1'b1 || obs_gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_gnt: got gnt=%0b%0b expected 10", obs_gnt_a, obs_gnt_b);
    end
    we_a = 0;
    tick();
    req_a = 0;
    n_checks++;
    if (obs_gnt_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_gnt: got %0b expected 1", obs_gnt_a);
    end
    n_checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 2'd3) begin
      n_fail++;
      $display("FAIL rd_data: got rvalid=%0b rdata=%0d expected 1 3", rvalid_a, rdata_a);
    end
    n_checks++;
    if (cnt_a !== 4'd2) begin
      n_fail++;
      $display("FAIL rd_cnt: got %0d expected 2", cnt_a);
    end
    tick();
    n_checks++;
    if (rvalid_a !== 1'b0 || rdata_a !== 2'd3) begin
      n_fail++;
      $display("FAIL rd_hold: got rvalid=%0b rdata=%0d expected 0 3", rvalid_a, rdata_a);
    end
  endtask

  task automatic test_contention();
    apply_reset(1);
    req_a = 1; we_a = 0; addr_a = 2'd2;
    req_b = 1; we_b = 0; addr_b = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs_gnt_a !== (i % 2 == 0) || obs_gnt_b !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL contend_gnt cycle %0d: got gnt=%0b%0b expected %0b%0b",
                 i, obs_gnt_a, obs_gnt_b, (i % 2 == 0), (i % 2 == 1));
      end
      n_checks++;
      if (rvalid_a !== (i % 2 == 0) || rvalid_b !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL contend_rvalid cycle %0d: got %0b%0b expected %0b%0b",
                 i, rvalid_a, rvalid_b, (i % 2 == 0), (i % 2 == 1));
      end
    end
    req_a = 0; req_b = 0;
    n_checks++;
    if (cnt_a !== 4'd2 || cnt_b !== 4'd2) begin
      n_fail++;
      $display("FAIL contend_cnt: got a=%0d b=%0d expected 2 2", cnt_a, cnt_b);
    end
  endtask

  task automatic test_hazard();
    apply_reset(1);
    req_a = 1; we_a = 1; addr_a = 2'd1; wdata_a = 2'd2;
    tick();
    apply_reset(1);
    req_a = 1; we_a = 1; addr_a = 2'd1; wdata_a = 2'd1;
    req_b = 1; we_b = 0; addr_b = 2'd1;
    tick();
    req_a = 0;
    n_checks++;
    if (obs_gnt_a !== 1'b1 || obs_gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_first: got gnt=%0b%0b expected 10", obs_gnt_a, obs_gnt_b);
    end
    tick();
    req_b = 0;
    n_checks++;
    if (obs_gnt_b !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_second: got gnt_b=%0b expected 1", obs_gnt_b);
    end
    n_checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 2'd1) begin
      n_fail++;
      $display("FAIL hazard_data: got rvalid_b=%0b rdata_b=%0d expected 1 1", rvalid_b, rdata_b);
    end
  endtask

  task automatic test_saturation();
    int exp_c;
    apply_reset(1);
    req_a = 1; we_a = 0; addr_a = 2'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_c = (i + 1 > CNT_MAX) ? CNT_MAX : i + 1;
      n_checks++;
      if (cnt_a !== exp_c[CW-1:0]) begin
        n_fail++;
        $display("FAIL sat_cnt_a cycle %0d: got %0d expected %0d", i, cnt_a, exp_c);
      end
    end
    req_a = 0;
    n_checks++;
    if (cnt_b !== '0) begin
      n_fail++;
      $display("FAIL sat_cnt_b: got %0d expected 0", cnt_b);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v, exp_v;
    v = DW'($urandom_range(1, (1 << DW) - 1));
    apply_reset(1);
    req_a = 1; we_a = 1; addr_a = 2'd3; wdata_a = v;
    tick();
    we_a = 0;
    tick();
    req_a = 0;
    n_checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== v) begin
      n_fail++;
      $display("FAIL mid_pre: got rvalid=%0b rdata=%0d expected 1 %0d", rvalid_a, rdata_a, v);
    end
    #1 reset = 1;
    #1;
    n_checks++;
    if (rvalid_a !== 1'b0 || rdata_a !== '0 || cnt_a !== '0) begin
      n_fail++;
      $display("FAIL mid_async: got rvalid=%0b rdata=%0d cnt=%0d expected 0 0 0",
               rvalid_a, rdata_a, cnt_a);
    end
    #1 reset = 0;
    model_reset();
    tick();
    while (m_clear_left > 0) tick();
`ifdef RAM_CLEAR_EN
    exp_v = '0;
`else
    exp_v = v;
`endif
    req_a = 1; we_a = 0; addr_a = 2'd3;
    tick();
    req_a = 0;
    n_checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== exp_v) begin
      n_fail++;
      $display("FAIL mid_retain: got rvalid=%0b rdata=%0d expected 1 %0d", rvalid_a, rdata_a, exp_v);
    end
  endtask

`ifdef RAM_CLEAR_EN
  task automatic test_clear();
    apply_reset(1);
    for (int i = 0; i < DEPTH; i++) begin
      req_a = 1; we_a = 1; addr_a = AW'(i); wdata_a = DW'($urandom_range(1, (1 << DW) - 1));
      tick();
    end
    apply_reset(0);
    req_a = 1; we_a = 0; addr_a = 2'd1;
    req_b = 1; we_b = 1; addr_b = 2'd2; wdata_b = 2'd3;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_checks++;
      if (obs_busy !== 1'b1 || obs_gnt_a !== 1'b0 || obs_gnt_b !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_busy cycle %0d: got busy=%0b gnt=%0b%0b expected 1 00",
                 i, obs_busy, obs_gnt_a, obs_gnt_b);
      end
    end
    req_a = 0; req_b = 0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_done: got busy=%0b expected 0", busy);
    end
    @(negedge clk_2);
    for (int i = 0; i < DEPTH; i++) begin
      req_a = 1; we_a = 0; addr_a = AW'(i);
      tick();
      n_checks++;
      if (rvalid_a !== 1'b1 || rdata_a !== '0) begin
        n_fail++;
        $display("FAIL clear_read addr %0d: got rvalid=%0b rdata=%0d expected 1 0", i, rvalid_a, rdata_a);
      end
    end
    req_a = 0;
  endtask
`endif

  task automatic test_random();
    apply_reset(1);
    for (int i = 0; i < 300; i++) begin
      if (!(req_a && !exp_gnt_a)) begin
        req_a   = ($urandom_range(0, 3) != 0);
        we_a    = $urandom_range(0, 1) != 0;
        addr_a  = AW'($urandom_range(0, DEPTH - 1));
        wdata_a = DW'($urandom_range(0, (1 << DW) - 1));
      end
      if (!(req_b && !exp_gnt_b)) begin
        req_b   = ($urandom_range(0, 3) != 0);
        we_b    = $urandom_range(0, 1) != 0;
        addr_b  = AW'($urandom_range(0, DEPTH - 1));
        wdata_b = DW'($urandom_range(0, (1 << DW) - 1));
      end
      tick();
      n_checks++;
      if (obs_gnt_a !== exp_gnt_a || obs_gnt_b !== exp_gnt_b || obs_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL rand_gnt cycle %0d: got gnt=%0b%0b busy=%0b expected gnt=%0b%0b busy=%0b",
                 i, obs_gnt_a, obs_gnt_b, obs_busy, exp_gnt_a, exp_gnt_b, exp_busy);
      end
      n_checks++;
      if (rvalid_a !== m_rvalid_a || rvalid_b !== m_rvalid_b) begin
        n_fail++;
        $display("FAIL rand_rvalid cycle %0d: got %0b%0b expected %0b%0b",
                 i, rvalid_a, rvalid_b, m_rvalid_a, m_rvalid_b);
      end
      if (m_rdk_a) begin
        n_checks++;
        if (rdata_a !== m_rdata_a[DW-1:0]) begin
          n_fail++;
          $display("FAIL rand_rdata_a cycle %0d: got %0d expected %0d", i, rdata_a, m_rdata_a);
        end
      end
      if (m_rdk_b) begin
        n_checks++;
        if (rdata_b !== m_rdata_b[DW-1:0]) begin
          n_fail++;
          $display("FAIL rand_rdata_b cycle %0d: got %0d expected %0d", i, rdata_b, m_rdata_b);
        end
      end
      n_checks++;
      if (cnt_a !== m_cnt_a[CW-1:0] || cnt_b !== m_cnt_b[CW-1:0]) begin
        n_fail++;
        $display("FAIL rand_cnt cycle %0d: got a=%0d b=%0d expected a=%0d b=%0d",
                 i, cnt_a, cnt_b, m_cnt_a, m_cnt_b);
      end
    end
    req_a = 0;
    req_b = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = 0;
      m_known[i] = 0;
    end
    exp_gnt_a = 0;
    exp_gnt_b = 0;
    test_reset();
    test_write_read();
    test_contention();
    test_hazard();
    test_saturation();
    test_reset_mid();
`ifdef RAM_CLEAR_EN
    test_clear();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and controller for a single-port R/W RAM of 2**ADDR_WIDTH words × DATA_WIDTH bits.
- Sits between two client blocks (switch-driven test client, future datapath) and the RAM.
- Grants at most one access per clk_2 cycle and registers read data back to the winner.
- Keeps saturating per-requester grant counters for LED display.

Parameters:
ADDR_WIDTH, 2, RAM address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 2, RAM word width
CNT_WIDTH, 4, width of each saturating grant counter

Ports:
clk_2  in  1  system clock
reset  in  1  reset, asynchronous, active-high
req_a  in  1  requester A access request
we_a  in  1  A: 1=write, 0=read; valid while req_a=1
addr_a  in  ADDR_WIDTH  A address
wdata_a  in  DATA_WIDTH  A write data
gnt_a  out  1  A granted this cycle (combinational)
rvalid_a  out  1  A read data valid (registered)
rdata_a  out  DATA_WIDTH  A read data
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
busy  out  1  arbiter not accepting requests
cnt_a  out  CNT_WIDTH  saturating count of A grants
cnt_b  out  CNT_WIDTH  saturating count of B grants

Behaviour:
- Clock/reset: reset is asynchronous, active-high; clock is clk_2. All flops reset asynchronously.
- Reset values: rvalid_a/b=0, rdata_a/b=0, cnt_a/b=0, last_gnt=B (so A wins the first contention), state=SERVE (or CLEAR, see Optional Feature). RAM array is not reset.
- FSM states: CLEAR, SERVE.
  - CLEAR exists only with the optional feature.
  - In SERVE: busy=0.
- Grant logic (combinational, SERVE only):
  - Only req_a=1: gnt_a=1.
  - Only req_b=1: gnt_b=1.
  - Both requesting: grant the requester that is not last_gnt.
  - gnt_a and gnt_b are never both 1.
  - busy=1 forces both grants to 0.
- Commit: at the posedge where gnt_x=1, the access selected by x's we/addr/wdata is performed on the RAM. last_gnt<=x.
- Write:
  - mem[addr_x]<=wdata_x.
  - rvalid_x<=0 in the next cycle.
- Read:
  - rdata_x<=mem[addr_x]; rvalid_x<=1 for exactly the next cycle.
  - Latency 1 cycle.
  - rdata_x holds its last value when there is no new read.
- Ungranted requester: rvalid=0 next cycle; its request stays pending.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - req still high in the cycle after a grant counts as a new request. Back-to-back requests are allowed.
- Fairness under continuous dual requests: grants alternate A,B,A,B every cycle. No requester waits more than 1 cycle.
- Hazard: a write committed at edge N is visible to a read committed at edge N+1 or later. No same-cycle conflict is possible because only one access commits per edge.
- Counters:
  - cnt_x increments on each commit for x.
  - Stops at 2**CNT_WIDTH-1; no wrap.
- Reset mid-operation:
  - Any in-flight rvalid is dropped and outputs take their reset values immediately.
  - RAM contents are retained unless the optional feature is enabled.

Optional Feature:
- Macro: RAM_CLEAR_EN.
- When defined:
  - Reset enters CLEAR. busy=1 and grants are forced to 0.
  - An internal address counter writes 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle.
  - After the last address, go to SERVE. CLEAR takes exactly 2**ADDR_WIDTH cycles after reset deasserts.
  - Reset mid-CLEAR restarts the clear from address 0.
  - Counters do not count clear writes.
- When not defined:
  - No CLEAR state; reset goes directly to SERVE and busy is tied 0.
  - RAM contents after power-up are undefined.

Test Plan:
- After reset: A write addr=2 data=3, then A read addr=2 -> gnt_a=1 in both cycles; rvalid_a=1 and rdata_a=3 in the cycle after the read; cnt_a=2.
- From reset, req_a=req_b=1 held, both reads, for 4 cycles -> grants A,B,A,B; rvalid alternates accordingly; cnt_a=cnt_b=2.
- Same cycle: A writes addr=1 data=1, B reads addr=1 -> gnt_a first; gnt_b the next cycle; rdata_b=1 with rvalid_b=1 one cycle later.
- req_a held with B idle for 20 cycles, CNT_WIDTH=4 -> cnt_a saturates at 15; cnt_b=0.
- Reset pulsed while A is reading -> rvalid_a, rdata_a and counters go to 0 immediately without waiting for a clock edge; a subsequent read returns the pre-reset contents (macro off).
- RAM_CLEAR_EN defined, RAM preloaded with nonzero data, reset -> busy=1 for 4 cycles with requests ignored; then reads of addr 0..3 return 0.
